// File: rtl/effect_noise_gate.sv
// Hysteretic noise gate: peak envelope follower, hold timer and linear gain ramps, sample-synchronous on i_valid.
// Optional status outputs (o_gate_open, o_gain) are built when NOISE_GATE_STATUS_EN is defined.
module effect_noise_gate #(
    parameter int unsigned DECAY_SHIFT  = 6,
    parameter int unsigned HOLD_SAMPLES = 2400,
    parameter int unsigned ATTACK_STEP  = 32,
    parameter int unsigned RELEASE_STEP = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic [2:0]         i_level,
    input  logic signed [15:0] i_data,
    output logic signed [15:0] o_data,
    output logic               o_valid
`ifdef NOISE_GATE_STATUS_EN
    ,
    output logic               o_gate_open,
    output logic [8:0]         o_gain
`endif
);

    localparam int unsigned DW = 16;
    localparam int unsigned GW = 9;
    localparam int unsigned SW = GW + 1;
    localparam int unsigned PW = DW + GW + 1;
    localparam int unsigned HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    localparam logic [GW-1:0] GAIN_UNITY = GW'(256);
    localparam logic [SW-1:0] UNITY_WIDE = SW'(256);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_SAMPLES - 1);

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        CLOSING = 3'd4
    } state_t;

    state_t               state_q, state_next;
    logic [DW-1:0]        env_q, env_next;
    logic [GW-1:0]        gain_q, gain_next;
    logic [HW-1:0]        hold_q, hold_next;
    logic [DW-1:0]        abs_c;
    logic [DW-1:0]        env_cand_c;
    logic [DW-1:0]        open_th_c;
    logic [DW-1:0]        close_th_c;
    logic [SW-1:0]        gain_up_c;
    logic signed [PW-1:0] prod_c;
    logic signed [DW-1:0] data_next;

    // Magnitude, envelope candidate, thresholds and gated product
    always_comb begin
        abs_c      = '0;
        env_cand_c = '0;
        open_th_c  = DW'(16'd64 << i_level);
        close_th_c = open_th_c >> 1;
        gain_up_c  = {1'b0, gain_q} + SW'(ATTACK_STEP);
        prod_c     = PW'(i_data) * PW'($signed({1'b0, gain_q}));
        data_next  = i_enable ? DW'(prod_c >>> 8) : i_data;

        if (i_data == 16'sh8000)
            abs_c = 16'h7fff;
        else if (i_data[DW-1])
            abs_c = DW'(-i_data);
        else
            abs_c = DW'(i_data);

        env_cand_c = (abs_c >= env_q) ? abs_c : env_q - (env_q >> DECAY_SHIFT);
    end

    // Next-state and gain/hold updates, only on a valid sample
    always_comb begin
        state_next = state_q;
        env_next   = env_q;
        gain_next  = gain_q;
        hold_next  = hold_q;

        if (i_valid) begin
            env_next = env_cand_c;
            unique case (state_q)
                CLOSED: begin
                    // The attack ramp takes its first step on the sample that opens the gate.
                    if (env_cand_c >= open_th_c) begin
                        state_next = OPENING;
                        gain_next  = GW'(ATTACK_STEP);
                    end
                end
                OPENING: begin
                    if (env_cand_c < close_th_c) begin
                        state_next = CLOSING;
                    end else if (gain_up_c >= UNITY_WIDE) begin
                        state_next = OPEN;
                        gain_next  = GAIN_UNITY;
                    end else begin
                        gain_next = GW'(gain_up_c);
                    end
                end
                OPEN: begin
                    if (env_cand_c < close_th_c) begin
                        state_next = HOLD;
                        hold_next  = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (env_cand_c >= open_th_c)
                        state_next = OPEN;
                    else if (hold_q == '0)
                        state_next = CLOSING;
                    else
                        hold_next = hold_q - HW'(1);
                end
                CLOSING: begin
                    if (env_cand_c >= open_th_c) begin
                        state_next = OPENING;
                    end else if (gain_q <= GW'(RELEASE_STEP)) begin
                        state_next = CLOSED;
                        gain_next  = '0;
                    end else begin
                        gain_next = gain_q - GW'(RELEASE_STEP);
                    end
                end
                default: state_next = CLOSED;
            endcase
        end
    end

    // State, envelope, gain and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= CLOSED;
            env_q       <= '0;
            gain_q      <= '0;
            hold_q      <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
`ifdef NOISE_GATE_STATUS_EN
            o_gate_open <= 1'b0;
            o_gain      <= '0;
`endif
        end else begin
            state_q <= state_next;
            env_q   <= env_next;
            gain_q  <= gain_next;
            hold_q  <= hold_next;
            o_valid <= i_valid;
            if (i_valid) begin
                o_data      <= data_next;
`ifdef NOISE_GATE_STATUS_EN
                o_gate_open <= (state_next == OPEN) || (state_next == HOLD);
                o_gain      <= gain_next;
`endif
            end
        end
    end

endmodule
